cdb_result_queue: RTL and testbench
===================================

// Module: cdb_result_queue
// PURPOSE
//  Requester-side endpoint of the CDB arbitration protocol; one instance per FU CDB lane.
//  Buffers completed FU results in a FIFO and raises a CDB request while un-granted work exists.
//  Drives the head result onto its fu_outputs lane in the cycle the registered grant arrives.
//  Back-pressures the FU pipeline when full; supports whole-queue squash on mispredict.
// PARAMETERS
//  DEPTH   4   FIFO entries (power of 2, >=2)
//  TAG_W   6   physical register tag width
//  DATA_W  32  result data width
// PORTS
//  clock         in   1              clock
//  reset         in   1              reset, synchronous, active-high
//  squash        in   1              flush all buffered results
//  in_valid      in   1              FU presents a completed result
//  in_tag        in   TAG_W          destination physical tag
//  in_data       in   DATA_W         result value
//  in_ready      out  1              queue accepts in_* this cycle
//  cdb_req       out  1              request to CDB arbiter (this lane)
//  cdb_gnt       in   1              registered grant from arbiter (answers cdb_req of previous cycle)
//  out_valid     out  1              result valid on FU output lane to CDB
//  out_tag       out  TAG_W          result tag to CDB
//  out_data      out  DATA_W         result data to CDB
//  count         out  $clog2(DEPTH)+1  occupancy
//  protocol_err  out  1              sticky: grant received with no granted-pending entry
// BEHAVIOUR
//  - Reset: empty, head=tail=0, count=0, in_ready=1, cdb_req=0, out_*=0, protocol_err=0, inflight=0.
//  - Protocol: req sampled by arbiter in cycle t; grant seen in t+1 means the head entry that existed
//    in t is captured from out_* during t+1 (broadcast on CDB at t+2).
//  - inflight flag = cdb_req registered (1 cycle); head entry is "promised" while inflight.
//  - cdb_req = (count - inflight) > 0 and !squash (only request for entries not already awaiting grant).
//  - out_valid = cdb_gnt && count>0 && !dropped; out_tag/out_data = head entry; else out_*=0.
//  - Dequeue: on cdb_gnt with count>0 pop head at clock edge.
//  - Grant with inflight=0 or count=0: out_valid=0, no pop, protocol_err set until reset.
//  - Enqueue: in_valid && in_ready writes tail, tail wraps modulo DEPTH.
//  - in_ready = (count < DEPTH) || (cdb_gnt && count>0); full+grant allows same-cycle push/pop.
//  - Simultaneous push and pop: count unchanged, pointers both advance.
//  - in_valid && !in_ready: result NOT accepted; FU must hold. No overwrite ever.
//  - Empty queue with in_valid: entry written this edge; cdb_req rises next cycle (no bypass).
//  - squash: at edge, count=0, head=tail, inflight=0; in_valid same cycle discarded; cdb_req=0
//    that cycle. A cdb_gnt arriving the cycle after squash gives out_valid=0 (dropped), not an error.
//  - Reset mid-operation overrides squash/push/pop; protocol_err cleared.
//  - Throughput: 1 result/cycle with continuous grants; min latency in->CDB bus = 3 cycles.
// TESTING
//  1. Push tag=5 data=0xAA at t0 -> cdb_req=1 at t1; gnt at t2 -> out_valid=1 tag=5 data=0xAA, count 0 at t3.
//  2. Push 3 entries back-to-back, grant every cycle -> out tags in push order, cdb_req drops when count-inflight=0.
//  3. Fill DEPTH=4, hold in_valid -> in_ready=0; assert gnt -> in_ready=1 same cycle, count stays 4.
//  4. 2 entries, squash with gnt next cycle -> out_valid=0, count=0, protocol_err=0, cdb_req=0.
//  5. gnt with empty queue -> out_valid=0, protocol_err=1 sticky until reset.
//  6. Reset asserted with 3 entries inflight -> all outputs zero next cycle, in_ready=1.

Source files
------------

// File: rtl/cdb_result_queue.sv
// Requester-side CDB lane endpoint: buffers completed FU results, requests the CDB
// while un-promised work exists, and presents the head result in the grant cycle.
module cdb_result_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic                       in_valid,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       cdb_req,
  input  logic                       cdb_gnt,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       protocol_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              dropped_q, dropped_d;
  logic              err_q, err_d;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic not_empty;
  logic pop;
  logic push;
  logic gnt_err;

  always_comb begin
    not_empty = (count_q != '0);
    // A grant is only honoured for the head entry promised by last cycle's request;
    // a grant landing right after a squash belongs to flushed work and is dropped.
    pop       = cdb_gnt && inflight_q && not_empty && !dropped_q;
    gnt_err   = cdb_gnt && !pop && !dropped_q;
    in_ready  = (count_q < DEPTH_C) || pop;
    push      = in_valid && in_ready && !squash;
    cdb_req   = (count_q > {{PW{1'b0}}, inflight_q}) && !squash;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = cdb_req;
    dropped_d  = squash;
    err_d      = err_q | gnt_err;
    if (squash) begin
      head_d     = tail_q;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      dropped_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      dropped_q  <= dropped_d;
      err_q      <= err_d;
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      tag_mem[tail_q]  <= in_tag;
      data_mem[tail_q] <= in_data;
    end
  end

  always_comb begin
    out_valid = pop;
    out_tag   = pop ? tag_mem[head_q]  : '0;
    out_data  = pop ? data_mem[head_q] : '0;
  end

  assign count        = count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue: a scoreboard queue holds the results expected
// on the CDB lane, popped and compared whenever a grant should produce output.
module tb_cdb_result_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic              squash;
  logic              in_valid;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cdb_req;
  logic              cdb_gnt;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic              protocol_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } result_t;

  result_t sb[$];

  cdb_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data),
    .count(count), .protocol_err(protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Checks the lane output; when a result is expected it must match the scoreboard head.
  task automatic check_out(input string name, input logic exp_valid);
    result_t e;
    chk({name, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        chk({name, ".sb_nonempty"}, 64'(0), 64'(1));
      end else begin
        e = sb.pop_front();
        chk({name, ".out_tag"},  64'(out_tag),  64'(e.tag));
        chk({name, ".out_data"}, 64'(out_data), 64'(e.data));
      end
    end else begin
      chk({name, ".out_tag0"},  64'(out_tag),  64'(0));
      chk({name, ".out_data0"}, 64'(out_data), 64'(0));
    end
  endtask

  task automatic drive_push(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                            input logic accepted);
    in_valid = 1'b1;
    in_tag   = t;
    in_data  = d;
    if (accepted) sb.push_back({t, d});
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; in_valid = 1'b0; in_tag = '0; in_data = '0; cdb_gnt = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    settle();
    chk("rst.count", 64'(count), 64'(0));
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    chk("rst.cdb_req", 64'(cdb_req), 64'(0));
    chk("rst.protocol_err", 64'(protocol_err), 64'(0));
    check_out("rst", 1'b0);

    // Single result: push, request next cycle, grant one cycle later.
    drive_push(6'd5, 32'hAA, 1'b1);
    settle();
    chk("t1.req_no_bypass", 64'(cdb_req), 64'(0));
    next_cycle();
    in_valid = 1'b0;
    settle();
    chk("t1.req", 64'(cdb_req), 64'(1));
    chk("t1.count1", 64'(count), 64'(1));
    next_cycle();
    cdb_gnt = 1'b1;
    settle();
    check_out("t1.gnt", 1'b1);
    next_cycle();
    cdb_gnt = 1'b0;
    settle();
    chk("t1.count0", 64'(count), 64'(0));
    chk("t1.req_low", 64'(cdb_req), 64'(0));

    // Back-to-back pushes with continuous grants.
    drive_push(6'd10, 32'h1000, 1'b1);
    next_cycle();
    drive_push(6'd11, 32'h1100, 1'b1);
    settle();
    chk("t2.req_a", 64'(cdb_req), 64'(1));
    next_cycle();
    drive_push(6'd12, 32'h1200, 1'b1);
    cdb_gnt = 1'b1;
    settle();
    check_out("t2.a", 1'b1);
    chk("t2.req_b", 64'(cdb_req), 64'(1));
    next_cycle();
    in_valid = 1'b0;
    settle();
    check_out("t2.b", 1'b1);
    chk("t2.count_b", 64'(count), 64'(2));
    chk("t2.req_c", 64'(cdb_req), 64'(1));
    next_cycle();
    settle();
    check_out("t2.c", 1'b1);
    chk("t2.count_c", 64'(count), 64'(1));
    chk("t2.req_drop", 64'(cdb_req), 64'(0));
    next_cycle();
    cdb_gnt = 1'b0;
    settle();
    chk("t2.count0", 64'(count), 64'(0));
    chk("t2.req0", 64'(cdb_req), 64'(0));

    // Fill to DEPTH, hold a push, then grant to free a slot in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(6'(20 + i), 32'(32'h2000 + i), 1'b1);
      next_cycle();
    end
    drive_push(6'd24, 32'h2400, 1'b0);
    settle();
    chk("t3.full_count", 64'(count), 64'(DEPTH));
    chk("t3.not_ready", 64'(in_ready), 64'(0));
    next_cycle();
    settle();
    chk("t3.hold_count", 64'(count), 64'(DEPTH));
    cdb_gnt = 1'b1;
    settle();
    chk("t3.ready_gnt", 64'(in_ready), 64'(1));
    check_out("t3.gnt", 1'b1);
    sb.push_back({6'd24, 32'h2400});
    next_cycle();
    in_valid = 1'b0;
    cdb_gnt = 1'b0;
    settle();
    chk("t3.count_stays", 64'(count), 64'(DEPTH));
    cdb_gnt = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      check_out("t3.drain", 1'b1);
      chk("t3.drain_req", 64'(cdb_req), 64'(i < DEPTH - 1));
      next_cycle();
    end
    cdb_gnt = 1'b0;
    settle();
    chk("t3.count0", 64'(count), 64'(0));

    // Squash with two entries, then a late grant must be silently dropped.
    drive_push(6'd30, 32'h3000, 1'b1);
    next_cycle();
    drive_push(6'd31, 32'h3100, 1'b1);
    next_cycle();
    drive_push(6'd63, 32'hDEAD, 1'b0);
    squash = 1'b1;
    settle();
    chk("t4.req_squash", 64'(cdb_req), 64'(0));
    next_cycle();
    sb.delete();
    squash = 1'b0;
    in_valid = 1'b0;
    cdb_gnt = 1'b1;
    settle();
    check_out("t4.dropped", 1'b0);
    chk("t4.count0", 64'(count), 64'(0));
    chk("t4.req0", 64'(cdb_req), 64'(0));
    next_cycle();
    cdb_gnt = 1'b0;
    settle();
    chk("t4.no_err", 64'(protocol_err), 64'(0));
    chk("t4.count_after", 64'(count), 64'(0));

    // Grant with an empty queue is a protocol error that sticks.
    cdb_gnt = 1'b1;
    settle();
    check_out("t5.empty_gnt", 1'b0);
    next_cycle();
    cdb_gnt = 1'b0;
    settle();
    chk("t5.err", 64'(protocol_err), 64'(1));
    chk("t5.count0", 64'(count), 64'(0));

    // Three entries with one promised, then reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      drive_push(6'(40 + i), 32'(32'h4000 + i), 1'b1);
      next_cycle();
    end
    in_valid = 1'b0;
    settle();
    chk("t5.err_sticky", 64'(protocol_err), 64'(1));
    chk("t6.count3", 64'(count), 64'(3));
    next_cycle();
    reset = 1'b1;
    next_cycle();
    sb.delete();
    reset = 1'b0;
    settle();
    chk("t6.count", 64'(count), 64'(0));
    chk("t6.req", 64'(cdb_req), 64'(0));
    chk("t6.in_ready", 64'(in_ready), 64'(1));
    chk("t6.err_clr", 64'(protocol_err), 64'(0));
    check_out("t6", 1'b0);

    // Queue operates normally after reset.
    drive_push(6'd50, 32'h5050, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    cdb_gnt = 1'b1;
    settle();
    check_out("t7.gnt", 1'b1);
    next_cycle();
    cdb_gnt = 1'b0;
    settle();
    chk("t7.count0", 64'(count), 64'(0));
    chk("t7.sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
